// File: rtl/filter_pkg.sv
// Shared types and field layout for the particle_filter run sequencer.
// A parameter table entry is {rate[15:10], cache_num[9:0]}.
package filter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } sched_state_e;

    localparam int RATE_MSB          = 15;
    localparam int RATE_LSB          = 10;
    localparam int CACHE_MSB         = 9;
    localparam int CACHE_LSB         = 0;
    localparam int MAX_CACHE_NUM_DEF = 1022;

    // True when the cache_num field of a table word is within the legal range.
    function automatic logic cache_num_ok(input logic [15:0] word, input int max_cache);
        return int'(word[CACHE_MSB:CACHE_LSB]) <= max_cache;
    endfunction

endpackage

// File: rtl/filter_track_scheduler_wr_arb.sv
// Host write port into the parameter BRAM (port A).
// A write is committed only while the sequencer is idle and the cache_num
// field is legal; otherwise it is refused. Everything is registered, so the
// BRAM strobe and the ack/rej pulse appear one clock after the request.
module track_para_wr_arb
    import filter_pkg::*;
#(
    parameter int ADDR_WIDTH    = 14,
    parameter int MAX_CACHE_NUM = MAX_CACHE_NUM_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_allow_i,
    input  logic                  cfg_wr_en_i,
    input  logic [ADDR_WIDTH-1:0] cfg_wr_addr_i,
    input  logic [15:0]           cfg_wr_data_i,
    output logic                  cfg_wr_ack_o,
    output logic                  cfg_wr_rej_o,
    output logic                  para_wea_o,
    output logic [ADDR_WIDTH-1:0] para_addra_o,
    output logic [15:0]           para_dina_o
);

    // Check each request and either strobe the BRAM with ack, or pulse rej.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_wr_ack_o <= 1'b0;
            cfg_wr_rej_o <= 1'b0;
            para_wea_o   <= 1'b0;
            para_addra_o <= '0;
            para_dina_o  <= '0;
        end else begin
            cfg_wr_ack_o <= 1'b0;
            cfg_wr_rej_o <= 1'b0;
            para_wea_o   <= 1'b0;
            if (cfg_wr_en_i) begin
                if (wr_allow_i && cache_num_ok(cfg_wr_data_i, MAX_CACHE_NUM)) begin
                    para_wea_o   <= 1'b1;
                    cfg_wr_ack_o <= 1'b1;
                    para_addra_o <= cfg_wr_addr_i;
                    para_dina_o  <= {cfg_wr_data_i[RATE_MSB:RATE_LSB],
                                     cfg_wr_data_i[CACHE_MSB:CACHE_LSB]};
                end else begin
                    cfg_wr_rej_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/filter_track_scheduler.sv
// Run sequencer for particle_filter: IDLE -> ARM (wait for encoder index)
// -> RUN (laser on for N tracks) -> DRAIN (pipeline flush) -> IDLE + done.
// abort_i returns to IDLE from any state and outranks every other input.
// The parameter table may only be written while IDLE.
// dbg_state_o exposes the FSM state for checkers.
module filter_track_scheduler
    import filter_pkg::*;
#(
    parameter int ADDR_WIDTH    = 14,
    parameter int DRAIN_CYCLES  = 64,
    parameter int MAX_CACHE_NUM = MAX_CACHE_NUM_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH-1:0] track_num_i,
    input  logic                  encode_zero_flag_i,
    output logic                  laser_start_o,
    output logic [ADDR_WIDTH-1:0] track_idx_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    input  logic                  cfg_wr_en_i,
    input  logic [ADDR_WIDTH-1:0] cfg_wr_addr_i,
    input  logic [15:0]           cfg_wr_data_i,
    output logic                  cfg_wr_ack_o,
    output logic                  cfg_wr_rej_o,
    output logic                  para_wea_o,
    output logic [ADDR_WIDTH-1:0] para_addra_o,
    output logic [15:0]           para_dina_o,
    output logic [1:0]            dbg_state_o
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    sched_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] n_q;
    logic [ADDR_WIDTH-1:0] track_idx_q;
    logic [DRAIN_W-1:0]    drain_cnt_q;
    logic                  laser_q, done_q, err_q;
    logic                  last_track, drain_last, start_bad;

    assign last_track = (track_idx_q == n_q - ADDR_WIDTH'(1));
    assign drain_last = (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1));
    // A start is an error when busy or with zero tracks, unless abort masks it.
    assign start_bad  = start_i && !abort_i &&
                        ((state_q != ST_IDLE) || (track_num_i == '0));

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_i && (track_num_i != '0)) state_d = ST_ARM;
            ST_ARM:   if (encode_zero_flag_i) state_d = ST_RUN;
            ST_RUN:   if (encode_zero_flag_i && last_track) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort_i) state_d = ST_IDLE;
    end

    // State register, track/drain counters and registered status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            track_idx_q <= '0;
            drain_cnt_q <= '0;
            laser_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            // Laser follows RUN one clock late, but drops with abort at once.
            laser_q <= (state_q == ST_RUN) && !abort_i;
            done_q  <= (state_q == ST_DRAIN) && drain_last && !abort_i;
            err_q   <= start_bad;

            if (state_d == ST_IDLE) begin
                track_idx_q <= '0;
            end else if (state_q == ST_IDLE) begin
                track_idx_q <= '0;
                n_q         <= track_num_i;
            end else if ((state_q == ST_RUN) && encode_zero_flag_i && !last_track) begin
                track_idx_q <= track_idx_q + ADDR_WIDTH'(1);
            end

            if ((state_q == ST_DRAIN) && (state_d == ST_DRAIN)) begin
                drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
            end else begin
                drain_cnt_q <= '0;
            end
        end
    end

    assign laser_start_o = laser_q;
    assign track_idx_o   = track_idx_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign dbg_state_o   = state_q;

    track_para_wr_arb #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .MAX_CACHE_NUM (MAX_CACHE_NUM)
    ) u_wr_arb (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .wr_allow_i    (state_q == ST_IDLE),
        .cfg_wr_en_i   (cfg_wr_en_i),
        .cfg_wr_addr_i (cfg_wr_addr_i),
        .cfg_wr_data_i (cfg_wr_data_i),
        .cfg_wr_ack_o  (cfg_wr_ack_o),
        .cfg_wr_rej_o  (cfg_wr_rej_o),
        .para_wea_o    (para_wea_o),
        .para_addra_o  (para_addra_o),
        .para_dina_o   (para_dina_o)
    );

endmodule

// File: tb/tb_filter_track_scheduler.sv
// Bench for filter_track_scheduler. Directed stimulus pushes expected output
// events {edge, kind, payload} into exp_q; an independent monitor turns every
// observed output change/pulse into the same form and compares it in order.
// Inputs change 1 time unit after the falling edge, so the next rising edge
// that samples them is cyc+1; registered responses carry that edge number.
module tb_filter_track_scheduler;

    localparam int K_LASER = 1;
    localparam int K_BUSY  = 2;
    localparam int K_IDX   = 3;
    localparam int K_DONE  = 4;
    localparam int K_ERR   = 5;
    localparam int K_ACK   = 6;
    localparam int K_REJ   = 7;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i, abort_i, encode_zero_flag_i, cfg_wr_en_i;
    logic [13:0] track_num_i, cfg_wr_addr_i;
    logic [15:0] cfg_wr_data_i;
    logic        laser_start_o, busy_o, done_o, err_o;
    logic        cfg_wr_ack_o, cfg_wr_rej_o, para_wea_o;
    logic [13:0] track_idx_o, para_addra_o;
    logic [15:0] para_dina_o;
    logic [1:0]  dbg_state_o;

    logic [63:0] exp_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic        prev_laser = 1'b0, prev_busy = 1'b0;
    logic [13:0] prev_idx = '0;

    filter_track_scheduler dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .start_i            (start_i),
        .abort_i            (abort_i),
        .track_num_i        (track_num_i),
        .encode_zero_flag_i (encode_zero_flag_i),
        .laser_start_o      (laser_start_o),
        .track_idx_o        (track_idx_o),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .err_o              (err_o),
        .cfg_wr_en_i        (cfg_wr_en_i),
        .cfg_wr_addr_i      (cfg_wr_addr_i),
        .cfg_wr_data_i      (cfg_wr_data_i),
        .cfg_wr_ack_o       (cfg_wr_ack_o),
        .cfg_wr_rej_o       (cfg_wr_rej_o),
        .para_wea_o         (para_wea_o),
        .para_addra_o       (para_addra_o),
        .para_dina_o        (para_dina_o),
        .dbg_state_o        (dbg_state_o)
    );

    // Clock and edge counter.
    initial forever #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    task automatic ex(input int stamp, input int kind, input logic [31:0] pl);
        exp_q.push_back({stamp[27:0], kind[3:0], pl});
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic observe(input int kind, input logic [31:0] pl);
        logic [63:0] got, want;
        got = {cyc[27:0], kind[3:0], pl};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got edge=%0d kind=%0d payload=%h, expected none",
                     cyc, kind, pl);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                errors++;
                $display("FAIL event: got edge=%0d kind=%0d payload=%h, expected edge=%0d kind=%0d payload=%h",
                         got[63:36], got[35:32], got[31:0], want[63:36], want[35:32], want[31:0]);
            end
        end
    endtask

    // Monitor: sample on the falling edge, report events in a fixed kind order.
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (laser_start_o !== prev_laser) observe(K_LASER, {31'd0, laser_start_o});
            if (busy_o !== prev_busy)         observe(K_BUSY, {31'd0, busy_o});
            if (track_idx_o !== prev_idx)     observe(K_IDX, {18'd0, track_idx_o});
            if (done_o)                       observe(K_DONE, 32'd1);
            if (err_o)                        observe(K_ERR, 32'd1);
            if (para_wea_o || cfg_wr_ack_o)
                observe(K_ACK, {para_wea_o, cfg_wr_ack_o, para_addra_o, para_dina_o});
            if (cfg_wr_rej_o)                 observe(K_REJ, {31'd0, para_wea_o});
            prev_laser = laser_start_o;
            prev_busy  = busy_o;
            prev_idx   = track_idx_o;
        end
    end

    // ---------------- drivers ----------------
    task automatic next();
        @(negedge clk_i);
        #1;
    endtask

    task automatic clr();
        start_i = 1'b0; abort_i = 1'b0; encode_zero_flag_i = 1'b0;
        cfg_wr_en_i = 1'b0; rst_i = 1'b0;
    endtask

    // Ends the current pulse cycle.
    task automatic fin();
        next();
        clr();
    endtask

    task automatic idle(input int n);
        repeat (n) next();
    endtask

    task automatic do_start(input logic [13:0] n, output int e);
        next(); e = cyc + 1; start_i = 1'b1; track_num_i = n;
    endtask

    task automatic zero(output int e);
        next(); e = cyc + 1; encode_zero_flag_i = 1'b1;
    endtask

    task automatic wr(input logic [13:0] a, input logic [15:0] d, output int e);
        next(); e = cyc + 1; cfg_wr_en_i = 1'b1; cfg_wr_addr_i = a; cfg_wr_data_i = d;
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_laser"}, {31'd0, laser_start_o}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy_o},        32'd0);
        check({tag, "_idx"},   {18'd0, track_idx_o},   32'd0);
        check({tag, "_done"},  {31'd0, done_o},        32'd0);
        check({tag, "_err"},   {31'd0, err_o},         32'd0);
        check({tag, "_ack"},   {31'd0, cfg_wr_ack_o},  32'd0);
        check({tag, "_rej"},   {31'd0, cfg_wr_rej_o},  32'd0);
        check({tag, "_wea"},   {31'd0, para_wea_o},    32'd0);
        check({tag, "_state"}, {30'd0, dbg_state_o},   32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s, a, b, c, d, e;
        clr();
        rst_i = 1'b1;
        track_num_i = '0; cfg_wr_addr_i = '0; cfg_wr_data_i = '0;
        idle(4);
        all_zero("reset");
        rst_i = 1'b0;
        mon_en = 1'b1;
        idle(2);

        // T1: three tracks, index pulses 100 clocks apart.
        do_start(14'd3, s); ex(s, K_BUSY, 1); fin();
        idle(3);
        zero(a); ex(a + 1, K_LASER, 1); fin(); idle(98);
        zero(b); ex(b, K_IDX, 1); fin(); idle(98);
        zero(c); ex(c, K_IDX, 2); fin(); idle(98);
        zero(d);
        ex(d + 1, K_LASER, 0);
        ex(d + 64, K_BUSY, 0); ex(d + 64, K_IDX, 0); ex(d + 64, K_DONE, 1);
        fin(); idle(70);

        // T2: start with zero tracks.
        do_start(14'd0, e); ex(e, K_ERR, 1); fin(); idle(3);

        // T4: IDLE writes, including the cache_num boundary.
        wr(14'h0005, 16'h0C10, e); ex(e, K_ACK, {1'b1, 1'b1, 14'h0005, 16'h0C10}); fin();
        wr(14'h0006, 16'h03FF, e); ex(e, K_REJ, 32'd0); fin();
        wr(14'h0007, 16'h03FE, e); ex(e, K_ACK, {1'b1, 1'b1, 14'h0007, 16'h03FE}); fin();
        idle(3);

        // T3: N=5, abort two clocks after the second index pulse; a start
        // coincident with the abort must not raise err.
        do_start(14'd5, s); ex(s, K_BUSY, 1); fin(); idle(2);
        zero(a); ex(a + 1, K_LASER, 1); fin(); idle(5);
        zero(b); ex(b, K_IDX, 1); fin();
        next(); e = cyc + 1; abort_i = 1'b1; start_i = 1'b1; track_num_i = 14'd2;
        ex(e, K_LASER, 0); ex(e, K_BUSY, 0); ex(e, K_IDX, 0);
        fin(); idle(80);

        // T5: write and start while running are refused; scan completes.
        do_start(14'd2, s); ex(s, K_BUSY, 1); fin(); idle(2);
        zero(a); ex(a + 1, K_LASER, 1); fin(); idle(3);
        wr(14'h0010, 16'h0001, e); ex(e, K_REJ, 32'd0); fin();
        do_start(14'd9, e); ex(e, K_ERR, 1); fin(); idle(3);
        zero(b); ex(b, K_IDX, 1); fin(); idle(3);
        zero(d);
        ex(d + 1, K_LASER, 0);
        ex(d + 64, K_BUSY, 0); ex(d + 64, K_IDX, 0); ex(d + 64, K_DONE, 1);
        fin(); idle(70);

        // T6: reset in the middle of DRAIN.
        do_start(14'd2, s); ex(s, K_BUSY, 1); fin(); idle(2);
        zero(a); ex(a + 1, K_LASER, 1); fin(); idle(3);
        zero(b); ex(b, K_IDX, 1); fin(); idle(3);
        zero(d); ex(d + 1, K_LASER, 0); fin(); idle(10);
        next(); e = cyc + 1; rst_i = 1'b1;
        ex(e, K_BUSY, 0); ex(e, K_IDX, 0);
        fin();
        all_zero("after_rst");

        // New single-track scan, with a write in the same cycle as the start.
        next(); s = cyc + 1;
        start_i = 1'b1; track_num_i = 14'd1;
        cfg_wr_en_i = 1'b1; cfg_wr_addr_i = 14'h3FFF; cfg_wr_data_i = 16'hFFFE;
        ex(s, K_BUSY, 1); ex(s, K_ACK, {1'b1, 1'b1, 14'h3FFF, 16'hFFFE});
        fin(); idle(2);
        zero(a); ex(a + 1, K_LASER, 1); fin(); idle(3);
        zero(d);
        ex(d + 1, K_LASER, 0);
        ex(d + 64, K_BUSY, 0); ex(d + 64, K_DONE, 1);
        fin(); idle(70);

        // Anything still expected never appeared.
        while (exp_q.size() > 0) begin
            logic [63:0] w;
            w = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: got nothing, expected edge=%0d kind=%0d payload=%h",
                     w[63:36], w[35:32], w[31:0]);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
